// File: rtl/inst_cache.sv
// inst_cache: direct-mapped read-only instruction cache; a miss refills the whole
// line from backing memory in word order, one beat per mem_ack.
module inst_cache #(
  parameter int LINES = 8,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        pc_enable,
  input  logic        inv,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [15:0] miss_count
);
  localparam int OW = $clog2(WORDS);
  localparam int IW = $clog2(LINES);
  localparam int TW = 30 - OW - IW;
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
  state_t          state_q;
  logic [LINES-1:0] valid_q;
  logic [TW-1:0]   tag_q [LINES];
  logic [31:0]     data_q [LINES][WORDS];
  logic [TW-1:0]   ftag_q;
  logic [IW-1:0]   fidx_q;
  logic [OW-1:0]   beat_q;
  logic            inv_seen_q;
  logic [15:0]     miss_q;
  logic [OW-1:0]   a_off;
  logic [IW-1:0]   a_idx;
  logic [TW-1:0]   a_tag;
  logic            hit;
  logic            last_beat;
  logic            unused;
  assign a_off = inst_addr[OW+1:2];
  assign a_idx = inst_addr[IW+OW+1:OW+2];
  assign a_tag = inst_addr[31:32-TW];
  assign unused = ^inst_addr[1:0];
  // an invalidate pulse suppresses the hit in the same cycle
  assign hit = state_q == IDLE && !inv && valid_q[a_idx] && tag_q[a_idx] == a_tag;
  assign last_beat = state_q == FILL && mem_ack && &beat_q;
  assign inst_valid = hit;
  assign pc_enable = hit;
  assign inst = hit ? data_q[a_idx][a_off] : '0;
  assign mem_req = state_q == FILL;
  assign mem_addr = mem_req ? {ftag_q, fidx_q, beat_q, 2'b00} : '0;
  assign miss_count = miss_q;
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      valid_q <= '0;
      ftag_q <= '0;
      fidx_q <= '0;
      beat_q <= '0;
      inv_seen_q <= 1'b0;
      miss_q <= '0;
    end else begin
      if (inv) valid_q <= '0;
      case (state_q)
        IDLE: if (!inv && !hit) begin
          state_q <= FILL;
          miss_q <= miss_q + 16'd1;
          ftag_q <= a_tag;
          fidx_q <= a_idx;
          beat_q <= '0;
          inv_seen_q <= 1'b0;
          valid_q[a_idx] <= 1'b0;
        end
        FILL: begin
          if (inv) inv_seen_q <= 1'b1;
          if (mem_ack) beat_q <= beat_q + OW'(1);
          if (last_beat) begin
            valid_q[fidx_q] <= !(inv_seen_q || inv);
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // line storage is deliberately left unreset
  always_ff @(posedge clk) begin
    if (state_q == FILL && mem_ack) data_q[fidx_q][beat_q] <= mem_rdata;
    if (last_beat) tag_q[fidx_q] <= ftag_q;
  end
endmodule

// File: tb/tb_inst_cache.sv
// tb_inst_cache: directed fetch scenarios checked every cycle against a
// line-address model of the cache, plus literal expectations.
module tb_inst_cache;
  logic        clk = 1'b0;
  logic        rst_b = 1'b1;
  logic [31:0] inst_addr = '0;
  logic        inv = 1'b0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] inst;
  logic        inst_valid;
  logic        pc_enable;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [15:0] miss_count;

  inst_cache #(.LINES(8), .WORDS(4)) dut (
    .clk(clk), .rst_b(rst_b), .inst_addr(inst_addr), .inst(inst),
    .inst_valid(inst_valid), .pc_enable(pc_enable), .inv(inv),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit          m_valid [8];
  logic [31:0] m_base [8];
  logic [31:0] m_data [8][4];
  int          m_phase;
  logic [31:0] m_fill;
  int          m_beat;
  bit          m_inv;
  logic [15:0] m_miss;
  int          delay = 0;
  int          wait_cnt = 0;
  bit          force_ack = 1'b0;
  logic [31:0] salt = '0;
  bit          chk_en = 1'b0;
  logic [31:0] hit_list [3] = '{32'h40, 32'h48, 32'h4C};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic int lin(input logic [31:0] a);
    return int'(a[6:4]);
  endfunction

  function automatic bit m_hit();
    return m_phase == 0 && !inv && m_valid[lin(inst_addr)] &&
           m_base[lin(inst_addr)] == (inst_addr & ~32'hF);
  endfunction

  task automatic model_reset();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    m_phase = 0;
    m_beat = 0;
    m_inv = 1'b0;
    m_miss = '0;
    m_fill = '0;
  endtask

  task automatic model_step();
    bit h;
    int l;
    h = m_hit();
    if (!rst_b) begin
      model_reset();
      return;
    end
    if (inv) foreach (m_valid[i]) m_valid[i] = 1'b0;
    if (m_phase == 0) begin
      if (!inv && !h) begin
        m_phase = 1;
        m_miss = m_miss + 16'd1;
        m_fill = inst_addr & ~32'hF;
        m_beat = 0;
        m_inv = 1'b0;
        m_valid[lin(inst_addr)] = 1'b0;
      end
    end else if (m_phase == 1) begin
      if (inv) m_inv = 1'b1;
      if (mem_ack) begin
        l = lin(m_fill);
        m_data[l][m_beat] = mem_rdata;
        m_beat++;
        if (m_beat == 4) begin
          m_valid[l] = !m_inv;
          m_base[l] = m_fill;
          m_phase = 2;
        end
      end
    end else m_phase = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    if (m_phase == 1) begin
      mem_ack = wait_cnt == delay;
      wait_cnt = mem_ack ? 0 : wait_cnt + 1;
    end else begin
      mem_ack = force_ack;
      wait_cnt = 0;
    end
    mem_rdata = mem_ack ? (m_fill + 32'(4 * m_beat)) ^ salt : 32'hDEAD_BEEF;
  endtask

  task automatic wait_idle();
    bit seen = 1'b0;
    for (int n = 0; n < 300; n++) begin
      cyc();
      if (m_phase == 1) seen = 1'b1;
      if (seen && m_phase == 0) break;
    end
    chk("fill_completes", 32'(seen && m_phase == 0), 1);
  endtask

  task automatic wait_beat(input int b);
    for (int n = 0; n < 300; n++) begin
      cyc();
      if (m_phase == 1 && m_beat == b) break;
    end
    chk("beat_reached", 32'(m_phase == 1 && m_beat == b), 1);
  endtask

  always @(negedge clk) begin
    bit eh;
    logic [31:0] ei;
    if (chk_en) begin
      eh = m_hit();
      ei = eh ? m_data[lin(inst_addr)][inst_addr[3:2]] : '0;
      chk("inst_valid", 32'(inst_valid), 32'(eh));
      chk("pc_enable", 32'(pc_enable), 32'(eh));
      chk("inst", inst, ei);
      chk("mem_req", 32'(mem_req), 32'(m_phase == 1));
      if (m_phase == 1 || !rst_b)
        chk("mem_addr", mem_addr, m_phase == 1 ? m_fill + 32'(4 * m_beat) : 32'h0);
      chk("miss_count", 32'(miss_count), 32'(m_miss));
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    #2 rst_b = 1'b0;
    model_reset();
    chk_en = 1'b1;
    inst_addr = 32'h44;
    cyc(); cyc(); #1;
    chk("rst_valid", 32'(inst_valid), 0);
    chk("rst_miss", 32'(miss_count), 0);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_addr", mem_addr, 0);
    cyc(); rst_b = 1'b1; #1;
    chk("post_rst_valid", 32'(inst_valid), 0);
    chk("post_rst_pc_enable", 32'(pc_enable), 0);
    chk("post_rst_inst", inst, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      chk("cold_req", 32'(mem_req), 1);
      chk("cold_addr", mem_addr, 32'h40 + 32'(4 * i));
    end
    cyc(); #1;
    chk("done_req", 32'(mem_req), 0);
    chk("done_valid", 32'(inst_valid), 0);
    cyc(); #1;
    chk("cold_inst", inst, 32'h44);
    chk("cold_valid", 32'(inst_valid), 1);
    chk("cold_miss", 32'(miss_count), 1);
    foreach (hit_list[i]) begin
      cyc();
      inst_addr = hit_list[i];
      force_ack = hit_list[i] == 32'h48;
      #1;
      chk("hit_valid", 32'(inst_valid), 1);
      chk("hit_inst", inst, hit_list[i]);
      chk("hit_req", 32'(mem_req), 0);
    end
    force_ack = 1'b0;
    cyc(); #1;
    chk("hit_miss", 32'(miss_count), 1);
    inst_addr = 32'hC4;
    wait_idle(); #1;
    chk("conf_inst", inst, 32'hC4);
    chk("conf_valid", 32'(inst_valid), 1);
    inst_addr = 32'h44; #1;
    chk("conf_evicted", 32'(inst_valid), 0);
    wait_idle(); #1;
    chk("conf_back_inst", inst, 32'h44);
    chk("conf_miss", 32'(miss_count), 3);
    salt = 32'h1000_0000;
    delay = 5;
    inst_addr = 32'h104;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      cyc();
      if (mem_req) n++;
      else if (n > 0) break;
    end
    chk("slow_len", n, 24);
    cyc(); #1;
    chk("slow_inst", inst, 32'h1000_0104);
    chk("slow_valid", 32'(inst_valid), 1);
    chk("slow_miss", 32'(miss_count), 4);
    delay = 3;
    inst_addr = 32'h44; #1;
    chk("pre_inv_valid", 32'(inst_valid), 1);
    inv = 1'b1; #1;
    chk("inv_pulse_valid", 32'(inst_valid), 0);
    cyc(); inv = 1'b0; #1;
    chk("after_inv_valid", 32'(inst_valid), 0);
    chk("after_inv_miss", 32'(miss_count), 4);
    wait_beat(2);
    inv = 1'b1;
    cyc(); inv = 1'b0;
    wait_idle(); #1;
    chk("inv_fill_valid", 32'(inst_valid), 0);
    chk("inv_fill_miss", 32'(miss_count), 5);
    wait_idle(); #1;
    chk("refill_inst", inst, 32'h1000_0044);
    chk("refill_miss", 32'(miss_count), 6);
    inst_addr = 32'h104; #1;
    chk("inv_other_valid", 32'(inst_valid), 0);
    wait_idle(); #1;
    chk("inv_other_miss", 32'(miss_count), 7);
    delay = 4;
    inst_addr = 32'h1C4;
    wait_beat(1);
    cyc();
    rst_b = 1'b0;
    model_reset(); #1;
    chk("rst_mid_req", 32'(mem_req), 0);
    chk("rst_mid_addr", mem_addr, 0);
    chk("rst_mid_miss", 32'(miss_count), 0);
    cyc(); cyc();
    rst_b = 1'b1;
    inst_addr = 32'h44; #1;
    chk("rst_rel_valid", 32'(inst_valid), 0);
    wait_idle(); #1;
    chk("rst_rel_inst", inst, 32'h1000_0044);
    chk("rst_rel_miss", 32'(miss_count), 1);
    inst_addr = 32'h1C4; #1;
    chk("rst_partial_valid", 32'(inst_valid), 0);
    cyc();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
